control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/k_and_s_pkg.sv | 62 ++++++
 rtl/control_unit.sv | 121 ++++++++++++
 tb/tb_control_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K-and-S processor control path:
// decoded opcode set, control FSM states, ALU operation codes and the
// branch-condition helper.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_LOAD   = 3'd2,
    S_STORE  = 3'd3,
    S_ALU    = 3'd4,
    S_BRANCH = 3'd5,
    S_NEXT   = 3'd6,
    S_HALT   = 3'd7
  } ctrl_state_type;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // Branch condition from the flags visible in the branch cycle itself.
  // Non-branch opcodes never reach S_BRANCH, so they simply report 0.
  function automatic logic branch_taken(input decoded_instruction_type instr,
                                        input logic zero_f,
                                        input logic neg_f,
                                        input logic uovf_f);
    logic taken;
    taken = 1'b0;
    case (instr)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_f;
      I_BNZERO: taken = ~zero_f;
      I_BNEG:   taken = neg_f;
      I_BNNEG:  taken = ~neg_f;
      I_BOV:    taken = uovf_f;
      I_BNOV:   taken = ~uovf_f;
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the K-and-S datapath. Every instruction is
// FETCH -> DECODE -> one execute state; HALT parks until reset.
// instr_count advances once per retired instruction (each pc_enable cycle).
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [15:0]             instr_count
);

  ctrl_state_type state, state_next;
  logic [15:0]    cnt_q;

  // No current condition tests signed overflow; kept on the port for the datapath contract.
  logic unused_sovf;
  assign unused_sovf = signed_overflow;

  assign instr_count = cnt_q;

  // State register; reset always restarts at a clean fetch.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Retired-instruction counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)            cnt_q <= 16'd0;
    else if (pc_enable) cnt_q <= cnt_q + 16'd1;
  end

  // Next-state and output decode; everything defaults to inactive.
  always_comb begin
    state_next       = state;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      S_FETCH: begin
        ir_enable  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Register-file operand read happens here; only the dispatch matters.
        case (decoded_instruction)
          I_LOAD:                                        state_next = S_LOAD;
          I_STORE:                                       state_next = S_STORE;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR:             state_next = S_ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG,
          I_BOV, I_BNOV:                                 state_next = S_BRANCH;
          I_HALT:                                        state_next = S_HALT;
          default:                                       state_next = S_NEXT;
        endcase
      end
      S_LOAD: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        pc_enable        = 1'b1;
        state_next       = S_FETCH;
      end
      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        pc_enable        = 1'b1;
        state_next       = S_FETCH;
      end
      S_ALU: begin
        write_reg_enable = 1'b1;
        pc_enable        = 1'b1;
        state_next       = S_FETCH;
        case (decoded_instruction)
          I_ADD:   begin operation = ALU_ADD; flags_reg_enable = 1'b1; end
          I_AND:   begin operation = ALU_AND; flags_reg_enable = 1'b1; end
          I_OR:    begin operation = ALU_OR;  flags_reg_enable = 1'b1; end
          I_SUB:   begin operation = ALU_SUB; flags_reg_enable = 1'b1; end
          // MOVE passes the operand through as a|a without touching flags.
          default: begin operation = ALU_OR;  flags_reg_enable = 1'b0; end
        endcase
      end
      S_BRANCH: begin
        pc_enable  = 1'b1;
        branch     = branch_taken(decoded_instruction, zero_op, neg_op, unsigned_overflow);
        state_next = S_FETCH;
      end
      S_NEXT: begin
        pc_enable  = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halt       = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes the expected output
// vector of every cycle it drives; a monitor pops and compares mid-cycle.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decoded_instruction_type decoded_instruction = I_NOP;
  logic zero_op = 1'b0, neg_op = 1'b0, unsigned_overflow = 1'b0, signed_overflow = 1'b0;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable;
  logic flags_reg_enable, ram_write_enable, halt;
  logic [1:0]  operation;
  logic [15:0] instr_count;

  control_unit dut (
    .clk(clk), .rst(rst), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .branch(branch), .pc_enable(pc_enable),
    .ir_enable(ir_enable), .addr_sel(addr_sel), .c_sel(c_sel), .operation(operation),
    .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .ram_write_enable(ram_write_enable), .halt(halt), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        branch, pc_enable, ir_enable, addr_sel, c_sel, wre, fre;
    logic [1:0]  op;
    logic        rwe, halt;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;
  logic [15:0] model_cnt = 16'd0;
  bit          pre_pending = 1'b0;
  logic [15:0] pre_val = 16'd0;

  function automatic exp_t e_zero();
    exp_t e;
    e = '0;
    return e;
  endfunction
  function automatic exp_t e_fetch();
    exp_t e; e = '0; e.ir_enable = 1'b1; return e;
  endfunction
  function automatic exp_t e_load();
    exp_t e; e = '0; e.addr_sel = 1'b1; e.c_sel = 1'b1; e.wre = 1'b1; e.pc_enable = 1'b1; return e;
  endfunction
  function automatic exp_t e_store();
    exp_t e; e = '0; e.addr_sel = 1'b1; e.rwe = 1'b1; e.pc_enable = 1'b1; return e;
  endfunction
  function automatic exp_t e_alu(input logic [1:0] op, input logic fre);
    exp_t e; e = '0; e.wre = 1'b1; e.pc_enable = 1'b1; e.op = op; e.fre = fre; return e;
  endfunction
  function automatic exp_t e_br(input logic b);
    exp_t e; e = '0; e.pc_enable = 1'b1; e.branch = b; return e;
  endfunction
  function automatic exp_t e_next();
    exp_t e; e = '0; e.pc_enable = 1'b1; return e;
  endfunction
  function automatic exp_t e_halt();
    exp_t e; e = '0; e.halt = 1'b1; return e;
  endfunction

  // Drive one cycle's inputs just after the edge and queue its expected outputs.
  task automatic drive(input bit r, input decoded_instruction_type ins,
                       input logic z, input logic n, input logic uo,
                       input bit chk, input exp_t e, input string nm);
    @(posedge clk); #1;
    if (pre_pending) begin
      force dut.cnt_q = pre_val;
      release dut.cnt_q;
      model_cnt   = pre_val;
      pre_pending = 1'b0;
    end
    rst = r; decoded_instruction = ins;
    zero_op = z; neg_op = n; unsigned_overflow = uo; signed_overflow = ~uo;
    if (chk) begin
      e.cnt = model_cnt;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    if (r)                model_cnt = 16'd0;
    else if (e.pc_enable) model_cnt = model_cnt + 16'd1;
  endtask

  task automatic run_instr(input decoded_instruction_type ins, input logic z,
                           input logic n, input logic uo, input exp_t ex, input string nm);
    drive(1'b0, ins, z, n, uo, 1'b1, e_fetch(),  {nm, "_fetch"});
    drive(1'b0, ins, z, n, uo, 1'b1, e_zero(),   {nm, "_decode"});
    drive(1'b0, ins, z, n, uo, 1'b1, ex,         {nm, "_exec"});
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    exp_t  e, a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable,
            flags_reg_enable, operation, ram_write_enable, halt, instr_count};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got br=%b pc=%b ir=%b as=%b cs=%b wre=%b fre=%b op=%b rwe=%b h=%b cnt=%h want br=%b pc=%b ir=%b as=%b cs=%b wre=%b fre=%b op=%b rwe=%b h=%b cnt=%h",
                 nm, a.branch, a.pc_enable, a.ir_enable, a.addr_sel, a.c_sel, a.wre, a.fre, a.op, a.rwe, a.halt, a.cnt,
                 e.branch, e.pc_enable, e.ir_enable, e.addr_sel, e.c_sel, e.wre, e.fre, e.op, e.rwe, e.halt, e.cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two cycles, then ADD.
    drive(1'b1, I_ADD, 0, 0, 0, 1'b0, e_zero(), "rst");
    drive(1'b1, I_ADD, 0, 0, 0, 1'b0, e_zero(), "rst");
    run_instr(I_ADD, 0, 0, 0, e_alu(ALU_ADD, 1'b1), "add");

    // Conditional branches, taken and not taken.
    run_instr(I_BZERO,  1, 0, 0, e_br(1'b1), "bzero_t");
    run_instr(I_BZERO,  0, 0, 0, e_br(1'b0), "bzero_nt");
    run_instr(I_BRANCH, 0, 0, 0, e_br(1'b1), "branch");
    run_instr(I_BNZERO, 0, 0, 0, e_br(1'b1), "bnzero_t");
    run_instr(I_BNZERO, 1, 0, 0, e_br(1'b0), "bnzero_nt");
    run_instr(I_BNEG,   0, 1, 0, e_br(1'b1), "bneg_t");
    run_instr(I_BNNEG,  0, 1, 0, e_br(1'b0), "bnneg_nt");
    run_instr(I_BOV,    0, 0, 1, e_br(1'b1), "bov_t");
    run_instr(I_BOV,    0, 0, 0, e_br(1'b0), "bov_nt");
    run_instr(I_BNOV,   0, 0, 0, e_br(1'b1), "bnov_t");

    // Memory and remaining ALU operations.
    run_instr(I_STORE, 0, 0, 0, e_store(), "store");
    run_instr(I_LOAD,  0, 0, 0, e_load(),  "load");
    run_instr(I_MOVE,  0, 0, 0, e_alu(ALU_OR,  1'b0), "move");
    run_instr(I_SUB,   0, 0, 0, e_alu(ALU_SUB, 1'b1), "sub");
    run_instr(I_AND,   0, 0, 0, e_alu(ALU_AND, 1'b1), "and");
    run_instr(I_OR,    0, 0, 0, e_alu(ALU_OR,  1'b1), "or");
    run_instr(I_NOP,   0, 0, 0, e_next(), "nop");

    // Counter wrap: bring the count to 0xFFFE, then two NOPs.
    pre_val = 16'hFFFE;
    pre_pending = 1'b1;
    run_instr(I_NOP, 0, 0, 0, e_next(), "nop_fffe");
    run_instr(I_NOP, 0, 0, 0, e_next(), "nop_ffff");

    // ADD interrupted by reset during its execute cycle.
    drive(1'b0, I_ADD, 0, 0, 0, 1'b1, e_fetch(), "addrst_fetch");
    drive(1'b0, I_ADD, 0, 0, 0, 1'b1, e_zero(),  "addrst_decode");
    drive(1'b1, I_ADD, 0, 0, 0, 1'b1, e_alu(ALU_ADD, 1'b1), "addrst_exec");
    run_instr(I_LOAD, 0, 0, 0, e_load(), "after_rst_load");

    // HALT: parked for 20 cycles, then a one-cycle reset.
    drive(1'b0, I_HALT, 0, 0, 0, 1'b1, e_fetch(), "halt_fetch");
    drive(1'b0, I_HALT, 0, 0, 0, 1'b1, e_zero(),  "halt_decode");
    for (int i = 0; i < 20; i++)
      drive(1'b0, I_HALT, 0, 0, 0, 1'b1, e_halt(), "halt_hold");
    drive(1'b1, I_HALT, 0, 0, 0, 1'b1, e_halt(), "halt_rst");
    run_instr(I_STORE, 0, 0, 0, e_store(), "after_halt_store");
    drive(1'b0, I_NOP, 0, 0, 0, 1'b1, e_fetch(), "final_fetch");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
